// File: rtl/ram_access_ctrl.sv
// Arbitrates CPU instruction fetch and data load/store onto one PSRAM user channel.
// Optional read timeout (sticky err) is enabled by defining RAM_CTRL_RD_TIMEOUT_EN.
module ram_access_ctrl #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 32,
  parameter int WR_CYCLES  = 14,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  input  logic                mem_calib,
  output logic                mem_cmd,
  output logic                mem_cmd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_data_mask,
  input  logic [DATA_W-1:0]   mem_rd_data,
  input  logic                mem_rd_data_valid,
  output logic                err,
  output logic [2:0]          state_dbg
);

  localparam int BE_W    = DATA_W / 8;
  localparam int CNT_MAX = (WR_CYCLES > RD_TIMEOUT) ? WR_CYCLES : RD_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WR_REC  = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_d_q;
  logic             is_wr_q;
  logic [BE_W-1:0]  be_q;
  logic             grant;
  logic             rd_capture;
  logic             rd_timeout;
  logic             d_req;
  logic             d_done;
  logic             if_done;

  // Handshake: a requester raises its request level with stable operands and
  // holds it; the single cycle its stall is low (RESP) is the completion cycle.
  assign d_req    = d_ren | d_wen;
  assign d_done   = (state_q == RESP) &  gnt_d_q;
  assign if_done  = (state_q == RESP) & ~gnt_d_q;
  assign d_stall  = d_req  & ~d_done;
  assign if_stall = if_req & ~if_done;

  assign state_dbg     = state_q;
  assign mem_cmd_en    = (state_q == ISSUE);
  assign mem_cmd       = (state_q == ISSUE) & is_wr_q;
  assign mem_data_mask = (state_q != ISSUE) ? {BE_W{1'b1}} :
                         (is_wr_q ? ~be_q : {BE_W{1'b0}});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant      = 1'b0;
    rd_capture = 1'b0;
    rd_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_calib && (d_req || if_req)) begin
          grant   = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = is_wr_q ? WR_REC : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_rd_data_valid) begin
          rd_capture = 1'b1;
          state_d    = RESP;
        end
`ifdef RAM_CTRL_RD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          rd_timeout = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WR_REC: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) state_d = RESP;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_d_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      be_q        <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        // Data port wins; ren+wen together is treated as a store.
        gnt_d_q  <= d_req;
        is_wr_q  <= d_req & d_wen;
        mem_addr <= d_req ? d_addr : if_addr;
        if (d_req) begin
          mem_wr_data <= d_wdata;
          be_q        <= d_be;
        end
      end
      if (rd_capture) begin
        if (gnt_d_q) d_rdata  <= mem_rd_data;
        else         if_rdata <= mem_rd_data;
      end else if (rd_timeout) begin
        if (gnt_d_q) d_rdata  <= '0;
        else         if_rdata <= '0;
      end
    end
  end

`ifdef RAM_CTRL_RD_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!reset)          err_q <= 1'b0;
    else if (rd_timeout) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: behavioural PSRAM responder plus a
// transaction-level reference memory driven from the requests themselves.
module tb_ram_access_ctrl;
  localparam int ADDR_W     = 21;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int WR_CYCLES  = 14;
  localparam int RD_TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  logic              d_ren, d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;
  logic              mem_calib;
  logic              mem_cmd, mem_cmd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BE_W-1:0]   mem_data_mask;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_data_valid;
  logic              err;
  logic [2:0]        state_dbg;

  ram_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(WR_CYCLES), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_calib(mem_calib), .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask), .mem_rd_data(mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_d  = '0;
  logic [DATA_W-1:0] exp_if = '0;
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] bus_mem [logic [ADDR_W-1:0]];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_init(input logic [ADDR_W-1:0] a);
    return {a[7:0], ~a[7:0], a[15:8], 8'h5A};
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic ref_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] v;
    v = ref_rd(a);
    for (int i = 0; i < BE_W; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
    ref_mem[a] = v;
  endtask

  // ---------------- PSRAM responder ----------------
  int               rsp_delay = 1;
  int               rsp_cnt   = -1;
  bit               rsp_mute  = 1'b0;
  bit               rsp_stray = 1'b0;
  logic [DATA_W-1:0] rsp_data;

  always @(negedge clk) begin
    logic [DATA_W-1:0] v;
    mem_rd_data_valid = 1'b0;
    mem_rd_data       = $urandom;
    if (rsp_stray) begin
      rsp_stray         = 1'b0;
      mem_rd_data_valid = 1'b1;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = rsp_data;
        rsp_cnt           = -1;
      end
    end
    if (mem_cmd_en) begin
      if (mem_cmd) begin
        v = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : mem_init(mem_addr);
        for (int i = 0; i < BE_W; i++)
          if (!mem_data_mask[i]) v[8*i +: 8] = mem_wr_data[8*i +: 8];
        bus_mem[mem_addr] = v;
      end else if (!rsp_mute) begin
        rsp_data = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : mem_init(mem_addr);
        rsp_cnt  = rsp_delay;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input bit port_d, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic [BE_W-1:0] be, input int rdelay, input bit drop_calib);
    bit is_wr;
    int exp_done, k, done_k, pulses;
    logic [BE_W-1:0]   exp_mask;
    logic [DATA_W-1:0] exp_rd;
    is_wr    = port_d && wr;
    exp_done = is_wr ? 2 + WR_CYCLES : 2 + rdelay;
    exp_mask = is_wr ? ~be : '0;
    rsp_delay = rdelay;
    if (port_d) begin
      d_ren = rd; d_wen = wr; d_addr = a; d_wdata = wd; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    if (is_wr) ref_wr(a, wd, be);
    else       exp_q.push_back(ref_rd(a));
    #1;
    check("stall_at_request", port_d ? d_stall : if_stall, 1'b1);
    k = 0; done_k = -1; pulses = 0;
    while (done_k < 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (mem_cmd_en) pulses++;
      if (k == 1) begin
        check("cmd_en", mem_cmd_en, 1'b1);
        check("cmd", mem_cmd, is_wr);
        check("cmd_addr", mem_addr, a);
        check("cmd_mask", mem_data_mask, exp_mask);
        if (is_wr) check("cmd_wr_data", mem_wr_data, wd);
      end
      if (k == 2) begin
        if (is_wr) check("wr_rec_mask", mem_data_mask, 4'hF);
        if (drop_calib) mem_calib = 1'b0;
      end
      if (!(port_d ? d_stall : if_stall)) done_k = k;
    end
    check("done_cycle", done_k, exp_done);
    check("cmd_pulses", pulses, 1);
    d_ren = 1'b0; d_wen = 1'b0; if_req = 1'b0; mem_calib = 1'b1;
    if (!is_wr) begin
      exp_rd = exp_q.pop_front();
      if (port_d) exp_d = exp_rd;
      else        exp_if = exp_rd;
    end
    @(negedge clk);
    check("d_rdata", d_rdata, exp_d);
    check("if_rdata", if_rdata, exp_if);
  endtask

  task automatic run_contention(input logic [ADDR_W-1:0] ad, input logic [ADDR_W-1:0] ai,
                                input int rdelay);
    int k, kd, ki;
    logic [ADDR_W-1:0] cmd_q[$];
    rsp_delay = rdelay;
    d_ren = 1'b1; d_wen = 1'b0; d_addr = ad;
    if_req = 1'b1; if_addr = ai;
    exp_q.push_back(ref_rd(ad));
    exp_q.push_back(ref_rd(ai));
    k = 0; kd = -1; ki = -1;
    while (ki < 0 && k < 300) begin
      @(negedge clk);
      k++;
      if (mem_cmd_en) cmd_q.push_back(mem_addr);
      if (!if_stall) ki = k;
      if (kd < 0 && !d_stall) begin
        kd = k;
        d_ren = 1'b0;
      end
    end
    if_req = 1'b0;
    check("cont_d_done", kd, 2 + rdelay);
    check("cont_if_done", ki, 5 + 2 * rdelay);
    check("cont_cmd_count", cmd_q.size(), 2);
    if (cmd_q.size() == 2) begin
      check("cont_first_addr", cmd_q[0], ad);
      check("cont_second_addr", cmd_q[1], ai);
    end
    exp_d  = exp_q.pop_front();
    exp_if = exp_q.pop_front();
    @(negedge clk);
    check("cont_d_rdata", d_rdata, exp_d);
    check("cont_if_rdata", if_rdata, exp_if);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pulses, lows, kind, k, done_k;
    reset = 1'b0; mem_calib = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_en", mem_cmd_en, 1'b0);
    check("rst_cmd", mem_cmd, 1'b0);
    check("rst_addr", mem_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    check("rst_mask", mem_data_mask, 4'hF);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_err", err, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_d_stall", d_stall, 1'b0);
    check("idle_if_stall", if_stall, 1'b0);

    // No calibration: request must stall with no command.
    mem_calib = 1'b0; d_ren = 1'b1; d_addr = 21'h00010;
    pulses = 0; lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_cmd_en) pulses++;
      if (!d_stall) lows++;
    end
    check("nocal_pulses", pulses, 0);
    check("nocal_stall_lows", lows, 0);
    d_ren = 1'b0; mem_calib = 1'b1;
    @(negedge clk);

    // Directed store, load, illegal ren+wen, fetch.
    run_txn(1'b1, 1'b0, 1'b1, 21'h00010, 32'hA5A5_1234, 4'b0011, 1, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 21'h00010, '0, '0, 5, 1'b0);
    run_txn(1'b1, 1'b1, 1'b1, 21'h00011, 32'h1357_9BDF, 4'b1001, 1, 1'b0);
    run_txn(1'b0, 1'b0, 1'b0, 21'h00011, '0, '0, 1, 1'b1);
    run_contention(21'h00010, 21'h00011, 3);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_txn(1'b1, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 7)), '0, '0,
                   $urandom_range(1, 8), $urandom_range(0, 3) == 0);
        1: run_txn(1'b1, 1'b0, 1'b1, ADDR_W'($urandom_range(0, 7)), $urandom,
                   BE_W'($urandom_range(0, 15)), 1, $urandom_range(0, 3) == 0);
        2: run_txn(1'b1, 1'b1, 1'b1, ADDR_W'($urandom_range(0, 7)), $urandom,
                   BE_W'($urandom_range(0, 15)), 1, 1'b0);
        default: run_txn(1'b0, 1'b0, 1'b0, ADDR_W'($urandom_range(0, 7)), '0, '0,
                         $urandom_range(1, 8), $urandom_range(0, 3) == 0);
      endcase
    end
    run_contention(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(8, 15)),
                   $urandom_range(1, 6));

    // Reset during WAIT_RD; the late valid must be ignored.
    rsp_delay = 8;
    d_ren = 1'b1; d_wen = 1'b0; d_addr = 21'h00003;
    repeat (3) @(negedge clk);
    reset = 1'b0; mem_calib = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0; lows = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_cmd_en) pulses++;
      if (!d_stall) lows++;
    end
    check("rst_mid_pulses", pulses, 0);
    check("rst_mid_no_done", lows, 0);
    check("rst_mid_d_rdata", d_rdata, 0);
    check("rst_mid_if_rdata", if_rdata, 0);
    d_ren = 1'b0; mem_calib = 1'b1;
    exp_d = '0; exp_if = '0;
    @(negedge clk);

    // Read with no return data.
    rsp_mute = 1'b1;
    d_ren = 1'b1; d_addr = 21'h00005;
`ifdef RAM_CTRL_RD_TIMEOUT_EN
    k = 0; done_k = -1;
    while (done_k < 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (!d_stall) done_k = k;
    end
    check("timeout_done_cycle", done_k, 2 + RD_TIMEOUT);
    check("timeout_err", err, 1'b1);
    d_ren = 1'b0;
    @(negedge clk);
    check("timeout_d_rdata", d_rdata, 0);
    rsp_stray = 1'b1;
    repeat (3) @(negedge clk);
    check("timeout_stray_d_rdata", d_rdata, 0);
    check("timeout_err_sticky", err, 1'b1);
`else
    lows = 0;
    repeat (2 + RD_TIMEOUT + 20) begin
      @(negedge clk);
      if (!d_stall) lows++;
    end
    check("no_timeout_stall_lows", lows, 0);
    check("no_timeout_err", err, 1'b0);
    reset = 1'b0; d_ren = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rsp_stray = 1'b1;
    repeat (3) @(negedge clk);
    check("no_timeout_d_rdata", d_rdata, 0);
    check("no_timeout_err_after", err, 1'b0);
`endif
    rsp_mute = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
